// File: rtl/mux_channel_scanner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mux_channel_scanner_if : control/mux handshake bundle for mux_channel_scanner
// Rev 1.0
// ---------------------------------------------------------------------------
interface mux_channel_scanner_if;
  logic       start;
  logic       CONT;
  logic       Y;
  logic [1:0] S;
  logic       busy;
  logic       done;
  logic [3:0] D;

  modport slave (
    input  start, CONT, Y,
    output S, busy, done, D
  );

  modport master (
    output start, CONT, Y,
    input  S, busy, done, D
  );
endinterface
`default_nettype wire

// File: rtl/mux_channel_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mux_channel_scanner : steps a 4-to-1 mux select through channels 0..3,
// samples Y after SETTLE cycles per channel and publishes a 4-bit word.
// Rev 1.0
// ---------------------------------------------------------------------------
module mux_channel_scanner #(
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_channel_scanner_if.slave  bus
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    sh_q;
  logic [1:0]    s_q;
  logic          busy_q;
  logic          done_q;
  logic [3:0]    d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (s_q != 2'd3) begin
              case (s_q)
                2'd0:    sh_q[0] <= bus.Y;
                2'd1:    sh_q[1] <= bus.Y;
                default: sh_q[2] <= bus.Y;
              endcase
              s_q <= s_q + 2'd1;
            end else begin
              // Final channel: publish the whole word at once so partial scans never leak into D.
              d_q    <= {bus.Y, sh_q};
              done_q <= 1'b1;
              s_q    <= '0;
              if (!bus.CONT) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.S    = s_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_channel_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux_channel_scanner : directed bench for SETTLE=2 and SETTLE=1 builds.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mux_channel_scanner;

  logic       clk;
  logic       a_rst, b_rst;
  logic [3:0] a_I, b_I;
  int         n_checks;
  int         n_fail;

  mux_channel_scanner_if a_if ();
  mux_channel_scanner_if b_if ();

  mux_channel_scanner #(.SETTLE(2)) u_dut_a (
    .clk (clk),
    .rst (a_rst),
    .bus (a_if.slave)
  );

  mux_channel_scanner #(.SETTLE(1)) u_dut_b (
    .clk (clk),
    .rst (b_rst),
    .bus (b_if.slave)
  );

  // Behavioural 4-to-1 mux closing the loop around each scanner.
  assign a_if.Y = a_I[a_if.S];
  assign b_if.Y = b_I[b_if.S];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SETTLE=2 scan; optional start pulses at cycles 3 and 5 must be ignored.
  task automatic run_a(input string tag, input bit do_start, input bit pulse,
                       input logic [3:0] exp_d, input bit exp_busy_end);
    if (do_start) begin
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
    end
    check({tag, "_s0"}, 32'(a_if.S), 32'd0);
    check({tag, "_busy0"}, 32'(a_if.busy), 32'd1);
    for (int n = 1; n <= 8; n++) begin
      tick();
      a_if.start = pulse && (n == 2 || n == 4);
      if (n < 8) begin
        check({tag, "_s"}, 32'(a_if.S), 32'((n / 2) % 4));
        check({tag, "_nodone"}, 32'(a_if.done), 32'd0);
        check({tag, "_busy"}, 32'(a_if.busy), 32'd1);
      end else begin
        check({tag, "_done"}, 32'(a_if.done), 32'd1);
        check({tag, "_D"}, 32'(a_if.D), 32'(exp_d));
        check({tag, "_busyend"}, 32'(a_if.busy), 32'(exp_busy_end));
        check({tag, "_sret"}, 32'(a_if.S), 32'd0);
      end
    end
    a_if.start = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    a_rst      = 1'b0;
    b_rst      = 1'b0;
    a_I        = 4'b0000;
    b_I        = 4'b0000;
    a_if.start = 1'b0;
    a_if.CONT  = 1'b0;
    b_if.start = 1'b0;
    b_if.CONT  = 1'b0;

    // Asynchronous reset before any clock edge.
    #2;
    a_rst = 1'b1;
    b_rst = 1'b1;
    #1;
    check("rst_S", 32'(a_if.S), 32'd0);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_done", 32'(a_if.done), 32'd0);
    check("rst_D", 32'(a_if.D), 32'd0);
    check("rst_b_D", 32'(b_if.D), 32'd0);
    tick();
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    // Continuous mode: mux input changes in the first done cycle, CONT dropped mid-scan.
    a_I       = 4'b1010;
    a_if.CONT = 1'b1;
    run_a("cont1", 1'b1, 1'b0, 4'b1010, 1'b1);
    a_I       = 4'b0110;
    a_if.CONT = 1'b0;
    run_a("cont2", 1'b0, 1'b0, 4'b0110, 1'b0);
    tick();
    check("cont_stop_done", 32'(a_if.done), 32'd0);
    check("cont_stop_busy", 32'(a_if.busy), 32'd0);

    // Start pulses while busy are dropped.
    a_I = 4'b1100;
    run_a("ign", 1'b1, 1'b1, 4'b1100, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("ign_noextra_done", 32'(a_if.done), 32'd0);
      check("ign_noextra_busy", 32'(a_if.busy), 32'd0);
    end

    // Plain single scan.
    a_I = 4'b1010;
    run_a("single", 1'b1, 1'b0, 4'b1010, 1'b0);
    tick();
    check("single_donelow", 32'(a_if.done), 32'd0);
    check("single_Dhold", 32'(a_if.D), 32'b1010);

    // Reset just after channel 1's sample edge.
    a_I        = 4'b0101;
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    repeat (4) tick();
    check("mid_s_before", 32'(a_if.S), 32'd2);
    #2;
    a_rst = 1'b1;
    #1;
    check("mid_D", 32'(a_if.D), 32'd0);
    check("mid_S", 32'(a_if.S), 32'd0);
    check("mid_busy", 32'(a_if.busy), 32'd0);
    check("mid_done", 32'(a_if.done), 32'd0);
    tick();
    #2;
    a_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("mid_nodone", 32'(a_if.done), 32'd0);
      check("mid_idle", 32'(a_if.busy), 32'd0);
    end
    run_a("rescan", 1'b1, 1'b0, 4'b0101, 1'b0);

    // SETTLE=1 build: one channel per cycle.
    b_I        = 4'b1100;
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    check("s1_s0", 32'(b_if.S), 32'd0);
    check("s1_busy0", 32'(b_if.busy), 32'd1);
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n < 4) begin
        check("s1_s", 32'(b_if.S), 32'(n));
        check("s1_nodone", 32'(b_if.done), 32'd0);
      end else begin
        check("s1_done", 32'(b_if.done), 32'd1);
        check("s1_D", 32'(b_if.D), 32'b1100);
        check("s1_busyend", 32'(b_if.busy), 32'd0);
        check("s1_sret", 32'(b_if.S), 32'd0);
      end
    end
    tick();
    check("s1_donelow", 32'(b_if.done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_channel_scanner.md
# mux_channel_scanner

Sequencing front end for the 4-to-1 multiplexer. It drives the mux select `S` through channels 0 to 3 in order and holds each select for a programmable settle time. It samples the mux output `Y` at the end of each settle window and presents the four sampled bits as one word `D` with a one-cycle `done` pulse. It sits between the control logic and the `MUX_4to1` instance: it feeds `S` and consumes `Y`.

## Interface
Parameters:
- `SETTLE`, default 2: clock cycles `S` is held per channel before `Y` is sampled. Legal values are ≥ 1.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request one scan. Sampled only in IDLE.
- `CONT` in 1: continuous mode. Sampled at the end of each scan.
- `Y` in 1: mux output. It must be combinationally valid for the current `S`.
- `S` out 2: mux select, registered.
- `busy` out 1: high while a scan is in progress.
- `done` out 1: one-cycle pulse when a scan completes. `D` is updated on the same edge.
- `D` out 4: last completed scan. `D[k]` is `Y` sampled while `S==k`.

## Operation
- Internal state:
  - FSM with states IDLE and WAIT.
  - Settle counter `cnt`, width `$clog2(SETTLE)` with a minimum of 1.
  - 3-bit shadow register `sh` for channels 0 to 2.
- Reset (asynchronous, immediate): state=IDLE, `S`=0, `busy`=0, `done`=0, `D`=0, `cnt`=0, `sh`=0.
- `done` defaults to 0 every cycle and is set only as described below.
- IDLE:
  - `start`=1 → `S`<=0, `cnt`<=0, `busy`<=1, go to WAIT.
  - Otherwise hold. `S` stays 0.
- WAIT with `cnt`≠SETTLE-1: `cnt`<=`cnt`+1. `S` is held.
- WAIT with `cnt`==SETTLE-1 (sample edge): `cnt`<=0, then:
  - `S`<3: `sh[S]`<=`Y`, `S`<=`S`+1, stay in WAIT.
  - `S`==3: `D`<={`Y`,`sh[2]`,`sh[1]`,`sh[0]`}, `done`<=1, `S`<=0.
    - If `CONT`=1, stay in WAIT and start the next scan immediately (`busy` stays 1).
    - Else go to IDLE with `busy`<=0.
- `start` while `busy`=1 is ignored. Requests are not queued.
- `D` updates atomically, only on a `done` edge. Partial scans never reach `D`.
- Reset mid-scan aborts the scan. No `done` is produced, the partial `sh` is discarded, and `D` returns to 0.
- Changing `CONT` mid-scan has effect only at that scan's final sample edge.
- SETTLE=1 gives one sample per cycle. `cnt` stays 0 and every WAIT cycle is a sample edge.

## Timing
- Let t0 be the edge where `start` is accepted in IDLE. `S`=0 and `busy`=1 from t0.
- Channel k is sampled at edge t0+(k+1)·SETTLE. `S` changes to k+1 (or to 0 after k=3) on that same edge.
- `done` is high, and `D` is valid, in the cycle after edge t0+4·SETTLE.
  - Start-to-done latency is 4·SETTLE cycles.
  - `busy` falls on the same edge unless `CONT`=1.
- Continuous mode: consecutive `done` pulses are exactly 4·SETTLE cycles apart, with no gap cycle.
- Earliest restart after a non-continuous scan: `start` high in the `done` cycle is accepted at the next edge, because the FSM is already in IDLE.
- `Y` must settle within SETTLE cycles of an `S` change. The sample uses `Y` in the cycle just before the sample edge.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `S`=00, `busy`=0, `done`=0, `D`=0000 immediately, with no clock edge needed.
- Single scan: SETTLE=2, mux `I`=4'b1010, one-cycle `start`.
  - `S` steps 0,1,2,3, two cycles each.
  - `done` is high exactly 8 cycles after the start edge.
  - `D`=1010, and `busy` falls with `done`.
  - `S` returns to 00.
- Continuous: `CONT`=1, `I`=1010 for the first scan, changed to 0110 during the first scan's `done` cycle.
  - First `done` gives `D`=1010.
  - Second `done` arrives 8 cycles later with `D`=0110.
  - `busy` stays 1 throughout.
- Ignored start: pulse `start` at cycles 3 and 5 of a scan → single `done` at cycle 8, `D` correct, no extra scan.
- Reset mid-scan: assert `rst` just after channel 1's sample edge (`D` previously 1010) → `D`=0000, no `done`. A new scan with `I`=0101 yields `D`=0101 8 cycles after its start.
- SETTLE=1 build: `I`=1100 → `S` changes every cycle, `done` 4 cycles after start, `D`=1100.
